// File: rtl/ht_ltf_multi_gen_if.sv
// rtl/ht_ltf_multi_gen_if.sv - sample stream bundle between LTF generator and its consumer
interface ht_ltf_multi_gen_if #(
  parameter int IQ_W = 16
);
  logic [2*IQ_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/ht_ltf_multi_gen.sv
// rtl/ht_ltf_multi_gen.sv - HT-LTF multi-symbol generator with cyclic prefix and P-matrix signs
module ht_ltf_multi_gen #(
  parameter int IQ_W    = 16,
  parameter int SYM_LEN = 64,
  parameter int CP_LEN  = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       tbl_we,
  input  logic [$clog2(SYM_LEN)-1:0] tbl_addr,
  input  logic [2*IQ_W-1:0]          tbl_data,
  input  logic                       start,
  input  logic [2:0]                 n_ltf,
  input  logic [1:0]                 stream_idx,
  ht_ltf_multi_gen_if.master         out,
  output logic                       started,
  output logic                       done,
  output logic                       busy,
  output logic                       err
);
  localparam int AW = $clog2(SYM_LEN);
  localparam logic [AW-1:0] CP_START = AW'(SYM_LEN - CP_LEN);
  localparam logic [AW-1:0] IDX_LAST = AW'(SYM_LEN - 1);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  state_t            state, nxt_state;
  logic [AW-1:0]     idx, nxt_idx;
  logic [1:0]        sym, nxt_sym;
  logic [1:0]        sidx_q;
  logic [2:0]        nltf_q;
  logic              first_q;
  logic [2*IQ_W-1:0] tbl [SYM_LEN];
  logic              xfer, last_sym, last_smp, n_legal;

  // Negate one component; the most negative code has no positive twin, so it clips.
  function automatic logic [IQ_W-1:0] neg_sat(input logic [IQ_W-1:0] x);
    if (x == {1'b1, {(IQ_W-1){1'b0}}}) return {1'b0, {(IQ_W-1){1'b1}}};
    return (~x) + 1'b1;
  endfunction

  function automatic logic [2*IQ_W-1:0] apply_sign(input logic [2*IQ_W-1:0] d, input logic neg);
    if (!neg) return d;
    return {neg_sat(d[2*IQ_W-1:IQ_W]), neg_sat(d[IQ_W-1:0])};
  endfunction

  assign xfer     = out.sample_valid & out.sample_ready;
  assign last_sym = ({1'b0, sym} == (nltf_q - 3'd1));
  assign last_smp = (state == BODY) && (idx == IDX_LAST) && last_sym;
  assign started  = xfer & first_q;
  assign done     = xfer & last_smp;
  assign n_legal  = (n_ltf == 3'd1) || (n_ltf == 3'd2) || (n_ltf == 3'd4);

  // Where the stream goes after the sample currently presented is transferred.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_sym   = sym;
    if (idx == IDX_LAST) begin
      if (state == CP) begin
        nxt_state = BODY;
        nxt_idx   = '0;
      end else if (state == BODY) begin
        if (last_sym) begin
          nxt_state = IDLE;
        end else begin
          nxt_state = CP;
          nxt_idx   = CP_START;
          nxt_sym   = sym + 2'd1;
        end
      end
    end else begin
      nxt_idx = idx + AW'(1);
    end
  end

  // Training table; deliberately outside reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy) tbl[tbl_addr] <= tbl_data;
  end

  // Sequencer: the output register always holds the sample addressed by state/idx/sym.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= IDLE;
      idx              <= '0;
      sym              <= '0;
      sidx_q           <= '0;
      nltf_q           <= '0;
      first_q          <= 1'b0;
      out.sample       <= '0;
      out.sample_valid <= 1'b0;
      busy             <= 1'b0;
      err              <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n_legal) begin
              state            <= CP;
              idx              <= CP_START;
              sym              <= 2'd0;
              sidx_q           <= stream_idx;
              nltf_q           <= n_ltf;
              first_q          <= 1'b1;
              out.sample       <= apply_sign(tbl[CP_START], stream_idx == 2'd3);
              out.sample_valid <= 1'b1;
              busy             <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          if (xfer) begin
            first_q <= 1'b0;
            state   <= nxt_state;
            idx     <= nxt_idx;
            sym     <= nxt_sym;
            if (nxt_state == IDLE) begin
              out.sample_valid <= 1'b0;
              busy             <= 1'b0;
            end else begin
              // Row r of P negates exactly column (r+1) mod 4.
              out.sample <= apply_sign(tbl[nxt_idx], nxt_sym == (sidx_q + 2'd1));
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ht_ltf_multi_gen.sv
// tb/tb_ht_ltf_multi_gen.sv - directed self-checking bench for ht_ltf_multi_gen
module tb_ht_ltf_multi_gen;
  logic        clk = 1'b0;
  logic        rstn;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        start;
  logic [2:0]  n_ltf;
  logic [1:0]  stream_idx;
  logic        started, done, busy, err;

  int          total_n = 0;
  int          bad_n = 0;
  logic [31:0] tbl_model [64];
  logic [31:0] cap16;

  ht_ltf_multi_gen_if #(.IQ_W(16)) sif ();

  ht_ltf_multi_gen #(.IQ_W(16), .SYM_LEN(64), .CP_LEN(16)) dut (
    .clk(clk), .rstn(rstn), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .n_ltf(n_ltf), .stream_idx(stream_idx), .out(sif),
    .started(started), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_n++;
    assert (obs === expv) else begin
      bad_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] sat_neg(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7fff;
    return 16'h0000 - x;
  endfunction

  function automatic logic [31:0] exp_sample(input int sidx, input int cnt);
    int k, p, a;
    logic neg;
    logic [31:0] d;
    k = cnt / 80;
    p = cnt % 80;
    a = (p < 16) ? 48 + p : p - 16;
    d = tbl_model[a];
    neg = (sidx == 0 && k == 1) || (sidx == 1 && k == 2) ||
          (sidx == 2 && k == 3) || (sidx == 3 && k == 0);
    if (neg) d = {sat_neg(d[31:16]), sat_neg(d[15:0])};
    return d;
  endfunction

  task automatic write_tbl(input int a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_addr = 6'(a); tbl_data = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    tbl_model[a] = d;
  endtask

  task automatic start_seq(input int n, input int sidx);
    start = 1'b1; n_ltf = 3'(n); stream_idx = 2'(sidx);
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_after_start", 64'(sif.sample_valid), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic consume(input int n, input int sidx, input int rnd, input int stop_at);
    int cnt, cyc, tot;
    logic [31:0] held;
    logic held_v;
    cnt = 0; cyc = 0; tot = n * 80; held_v = 1'b0; held = '0;
    while (cnt < tot && cyc < 5000 && cnt != stop_at) begin
      sif.sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("valid_gap", 64'(sif.sample_valid), 64'd1);
      if (held_v) check("stall_hold", 64'(sif.sample), 64'(held));
      if (sif.sample_valid && sif.sample_ready) begin
        check("sample", 64'(sif.sample), 64'(exp_sample(sidx, cnt)));
        check("started", 64'(started), 64'(cnt == 0));
        check("done", 64'(done), 64'(cnt == tot - 1));
        if (cnt == 16) cap16 = sif.sample;
        cnt++;
        held_v = 1'b0;
      end else begin
        check("stall_flags", 64'({started, done}), 64'd0);
        held = sif.sample;
        held_v = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (stop_at < 0) begin
      check("xfer_count", 64'(cnt), 64'(tot));
      check("valid_drop", 64'(sif.sample_valid), 64'd0);
      check("busy_clear", 64'(busy), 64'd0);
    end else begin
      check("stop_count", 64'(cnt), 64'(stop_at));
    end
  endtask

  initial begin
    rstn = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    start = 1'b0; n_ltf = '0; stream_idx = '0; sif.sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(sif.sample_valid), 64'd0);
    check("rst_sample", 64'(sif.sample), 64'd0);
    check("rst_flags", 64'({started, done, busy, err}), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 64; i++) write_tbl(i, {16'(i), 16'(-i)});

    // single symbol, continuous ready
    start_seq(1, 0);
    consume(1, 0, 0, -1);

    // four symbols, row 3, saturating entry at table[0]
    write_tbl(0, {16'h8000, 16'h0001});
    start_seq(4, 3);
    consume(4, 3, 0, -1);
    check("sat_entry", 64'(cap16), 64'h7fff_ffff);

    // random back-pressure
    start_seq(2, 1);
    consume(2, 1, 1, -1);

    // row 0 negates symbol 1
    start_seq(2, 0);
    consume(2, 0, 0, -1);

    // illegal symbol counts
    start = 1'b1; n_ltf = 3'd3; @(posedge clk); #1; start = 1'b0;
    check("err_n3", 64'(err), 64'd1);
    check("err_n3_idle", 64'({busy, sif.sample_valid}), 64'd0);
    @(posedge clk); #1;
    check("err_pulse_end", 64'(err), 64'd0);
    start = 1'b1; n_ltf = 3'd0; @(posedge clk); #1; start = 1'b0;
    check("err_n0", 64'(err), 64'd1);
    @(posedge clk); #1;

    // start and table write while busy are ignored, then abort by reset
    start_seq(2, 0);
    sif.sample_ready = 1'b0;
    start = 1'b1; n_ltf = 3'd3; tbl_we = 1'b1; tbl_addr = 6'd48; tbl_data = 32'hdead_beef;
    @(posedge clk); #1;
    start = 1'b0; tbl_we = 1'b0;
    check("busy_start_no_err", 64'(err), 64'd0);
    check("busy_held", 64'(busy), 64'd1);
    check("busy_sample_hold", 64'(sif.sample), 64'(exp_sample(0, 0)));
    consume(2, 0, 0, 40);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", 64'(sif.sample_valid), 64'd0);
    check("abort_sample", 64'(sif.sample), 64'd0);
    check("abort_flags", 64'({started, done, busy, err}), 64'd0);
    rstn = 1'b1;
    start_seq(1, 0);
    consume(1, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/ht_ltf_multi_gen.md
HT_LTF_MULTI_GEN -- requirements
Module: ht_ltf_multi_gen

Interface
REQ-001 Parameter IQ_W, default 16: bit width of each I and Q component.
REQ-002 Parameter SYM_LEN, default 64: samples per LTF symbol body, power of two.
REQ-003 Parameter CP_LEN, default 16: cyclic-prefix samples per symbol, range 1..SYM_LEN-1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 tbl_we  input  1  table write strobe.
REQ-007 tbl_addr  input  log2(SYM_LEN)  table write address.
REQ-008 tbl_data  input  2*IQ_W  table write data, {I[IQ_W-1:0], Q[IQ_W-1:0]}, two's complement.
REQ-009 start  input  1  one-cycle request to emit an LTF sequence.
REQ-010 n_ltf  input  3  number of LTF symbols, sampled at start; legal values 1, 2, 4.
REQ-011 stream_idx  input  2  P-matrix row selector, sampled at start.
REQ-012 sample  output  2*IQ_W  output sample, {I, Q}.
REQ-013 sample_valid  output  1  sample holds valid data.
REQ-014 sample_ready  input  1  downstream accepts the sample.
REQ-015 started  output  1  one-cycle pulse on the first accepted sample of a sequence.
REQ-016 done  output  1  one-cycle pulse on the last accepted sample of a sequence.
REQ-017 busy  output  1  high from accepted start until the cycle after done.
REQ-018 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-019 Internal table SHALL hold SYM_LEN samples; when tbl_we=1 and busy=0, entry tbl_addr SHALL be written; tbl_we while busy=1 SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, CP, BODY; reset state IDLE.
REQ-021 IDLE + start + legal n_ltf -> CP, with symbol counter=0, sample index=SYM_LEN-CP_LEN; n_ltf and stream_idx latched.
REQ-022 IDLE + start + illegal n_ltf (0,3,5,6,7) -> stay IDLE, err=1 next cycle.
REQ-023 start while busy=1 SHALL be ignored, with no err.
REQ-024 sample_valid SHALL rise exactly one cycle after an accepted start (registered table read).
REQ-025 Each symbol SHALL emit table[SYM_LEN-CP_LEN..SYM_LEN-1] (CP state), then table[0..SYM_LEN-1] (BODY state); total n_ltf*(CP_LEN+SYM_LEN) samples.
REQ-026 The index SHALL advance only on a transfer (sample_valid & sample_ready).
REQ-027 While sample_valid=1 and sample_ready=0, sample SHALL hold stable.
REQ-028 Back-to-back transfers SHALL sustain one sample per cycle with sample_ready held high.
REQ-029 CP->BODY SHALL occur after index SYM_LEN-1 transfers in CP, wrapping the index to 0.
REQ-030 BODY end, when symbols remain -> CP with symbol counter+1; at last symbol -> IDLE.
REQ-031 Sign per symbol k SHALL be P[stream_idx][k], using P rows: 0:{+,-,+,+} 1:{+,+,-,+} 2:{+,+,+,-} 3:{-,+,+,+}; for n_ltf=1 only column 0 applies; for n_ltf=2 only columns 0-1 apply.
REQ-032 Negation SHALL apply independently to I and Q in two's complement; -2^(IQ_W-1) SHALL saturate to 2^(IQ_W-1)-1.
REQ-033 started SHALL coincide with the first transfer; done SHALL coincide with the final transfer; both SHALL equal 1 for n_ltf=1 when CP_LEN+SYM_LEN=1 cannot occur.
REQ-034 After done, sample_valid SHALL drop in the next cycle unless stalled, and busy SHALL clear in the next cycle.

Reset
REQ-035 rstn=0 at a clock edge SHALL force IDLE and set sample_valid, started, done, busy and err to 0, and sample to 0.
REQ-036 Reset SHALL NOT clear table contents.
REQ-037 Reset mid-sequence SHALL abort the sequence; the next start SHALL begin a fresh sequence from CP index SYM_LEN-CP_LEN.

Verification
REQ-038 Load table[i]={i,-i}, n_ltf=1, stream_idx=0, sample_ready=1 -> 80 samples: table[48..63], then table[0..63]; started on sample 0; done on sample 79.
REQ-039 n_ltf=4, stream_idx=3 -> 320 samples; symbol 0 negated, symbols 1-3 unmodified; table[0]={16'h8000,16'h0001} emitted in symbol 0 as {16'h7FFF,16'hFFFF}.
REQ-040 Random sample_ready (50%) with n_ltf=2, stream_idx=1 -> output sequence identical to the ready=1 case; sample stable whenever stalled; exactly 160 transfers.
REQ-041 n_ltf=3 -> err pulse, busy=0, no sample_valid; start during busy -> ignored, no err; tbl_we during busy -> table unchanged.
REQ-042 rstn=0 at sample 40 of n_ltf=2 -> all outputs 0 the next cycle; a new start with n_ltf=1 -> exactly 80 correct samples.
